ovi_vpu_endpoint: RTL

//  VPU-side end of the OVI link: accepts issue/dispatch from the core-side bridge and returns

---
 rtl/ovi_vpu_endpoint.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ovi_vpu_endpoint.sv
// ovi_vpu_endpoint: VPU-side end of the OVI link.
// Queues issued instructions, runs memory handshakes and reports completion.
module ovi_vpu_endpoint #(
    parameter int QUEUE_DEPTH        = 4,
    parameter int SBID_W             = 5,
    parameter int VL_W               = 15,
    parameter int MEMDATA_W          = 512,
    parameter int INIT_STORE_CREDITS = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ISSUE_VALID,
    input  logic [31:0]          ISSUE_INSTR,
    input  logic [SBID_W-1:0]    ISSUE_SBID,
    input  logic [VL_W-1:0]      ISSUE_VL,
    input  logic [2:0]           ISSUE_VSEW,
    output logic                 ISSUE_CREDIT,
    input  logic                 DISPATCH_NEXT_SENIOR,
    input  logic                 DISPATCH_KILL,
    input  logic [SBID_W-1:0]    DISPATCH_SBID,
    output logic                 SYNC_START,
    input  logic                 MEMOP_SYNC_END,
    input  logic [SBID_W-1:0]    MEMOP_SBID,
    input  logic                 LOAD_VALID,
    input  logic [MEMDATA_W-1:0] LOAD_DATA,
    output logic                 STORE_VALID,
    output logic [MEMDATA_W-1:0] STORE_DATA,
    input  logic                 STORE_CREDIT,
    output logic                 COMPLETED_VALID,
    output logic [SBID_W-1:0]    COMPLETED_SBID,
    output logic [63:0]          COMPLETED_DEST_REG,
    output logic                 ERR
);
    localparam int PW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int SCW = (INIT_STORE_CREDITS > 0) ? $clog2(INIT_STORE_CREDITS + 1) : 1;
    localparam logic [SCW-1:0] CRED_INIT = SCW'(INIT_STORE_CREDITS);
    localparam logic [6:0] OP_LOAD  = 7'b0000111;
    localparam logic [6:0] OP_STORE = 7'b0100111;

    typedef enum logic [2:0] {
        S_IDLE, S_HEAD, S_SYNC, S_STORE, S_LOAD, S_WAIT, S_COMP, S_POP
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       instr_q [QUEUE_DEPTH];
    logic [SBID_W-1:0] sbid_q  [QUEUE_DEPTH];
    logic [VL_W-1:0]   vl_q    [QUEUE_DEPTH];
    logic [2:0]        vsew_q  [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] vld_q, senior_q, kill_q, hit;
    logic [PW-1:0]     head_q, tail_q;

    logic [SCW-1:0] cred_q, cred_d;
    logic [31:0]    sent_q, sent_d, rcvd_q, rcvd_d;
    logic [63:0]    csum_q, csum_d;
    logic           err_q, err_d;

    logic pop, full, push, push_hit, disp;
    logic is_load, is_store, end_hit, in_tx, cred_ok, store_valid;
    logic [6:0]        h_op;
    logic [SBID_W-1:0] h_sbid;
    logic [31:0]       bits, n_pkt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign h_op     = instr_q[head_q][6:0];
    assign h_sbid   = sbid_q[head_q];
    assign is_load  = (h_op == OP_LOAD);
    assign is_store = (h_op == OP_STORE);
    // Beat count: bits = vl * 2^(vsew+3), rounded up to whole beats.
    assign bits  = 32'(vl_q[head_q]) << ({1'b0, vsew_q[head_q]} + 4'd3);
    assign n_pkt = (bits + 32'(MEMDATA_W - 1)) / 32'(MEMDATA_W);

    assign pop      = (state_q == S_POP);
    assign full     = vld_q[tail_q];
    assign push     = ISSUE_VALID && (!full || pop);
    assign disp     = DISPATCH_NEXT_SENIOR || DISPATCH_KILL;
    assign push_hit = push && (ISSUE_SBID == DISPATCH_SBID);
    assign end_hit  = MEMOP_SYNC_END && (MEMOP_SBID == h_sbid);
    assign in_tx    = (state_q == S_STORE) || (state_q == S_WAIT);
    assign cred_ok  = STORE_CREDIT && in_tx;
    assign store_valid = (state_q == S_STORE) && (sent_q < n_pkt)
                         && (cred_q != '0);

    always_comb begin
        hit = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++)
            hit[i] = vld_q[i] && (sbid_q[i] == DISPATCH_SBID);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_q    <= '0;
            senior_q <= '0;
            kill_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                instr_q[i] <= '0;
                sbid_q[i]  <= '0;
                vl_q[i]    <= '0;
                vsew_q[i]  <= '0;
            end
        end else begin
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= ptr_inc(head_q);
            end
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (hit[i] && DISPATCH_NEXT_SENIOR) senior_q[i] <= 1'b1;
                if (hit[i] && DISPATCH_KILL)        kill_q[i]   <= 1'b1;
            end
            // Written last so a push into the slot being freed wins.
            if (push) begin
                vld_q[tail_q]    <= 1'b1;
                instr_q[tail_q]  <= ISSUE_INSTR;
                sbid_q[tail_q]   <= ISSUE_SBID;
                vl_q[tail_q]     <= ISSUE_VL;
                vsew_q[tail_q]   <= ISSUE_VSEW;
                senior_q[tail_q] <= DISPATCH_NEXT_SENIOR && push_hit;
                kill_q[tail_q]   <= DISPATCH_KILL && push_hit;
                tail_q           <= ptr_inc(tail_q);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cred_q  <= CRED_INIT;
            sent_q  <= '0;
            rcvd_q  <= '0;
            csum_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cred_q  <= cred_d;
            sent_q  <= sent_d;
            rcvd_q  <= rcvd_d;
            csum_q  <= csum_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (vld_q[head_q]) state_d = S_HEAD;
            S_HEAD: begin
                if (kill_q[head_q])
                    state_d = S_POP;
                else if (senior_q[head_q])
                    state_d = (is_load || is_store) ? S_SYNC : S_COMP;
            end
            S_SYNC:  state_d = is_store ? S_STORE : S_LOAD;
            S_STORE: if (sent_q == n_pkt) state_d = S_WAIT;
            S_LOAD:  if (end_hit) state_d = S_COMP;
            S_WAIT:  if (end_hit) state_d = S_COMP;
            S_COMP:  state_d = S_POP;
            S_POP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cred_d = cred_q;
        sent_d = sent_q;
        rcvd_d = rcvd_q;
        csum_d = csum_q;
        err_d  = err_q;
        if (store_valid) sent_d = sent_q + 32'd1;
        if (cred_ok && !store_valid) begin
            if (cred_q == CRED_INIT) err_d = 1'b1;
            else                     cred_d = cred_q + SCW'(1);
        end else if (!cred_ok && store_valid) begin
            cred_d = cred_q - SCW'(1);
        end
        if ((state_q == S_LOAD) && LOAD_VALID) begin
            rcvd_d = rcvd_q + 32'd1;
            csum_d = csum_q ^ LOAD_DATA[63:0];
        end
        if ((state_q == S_LOAD) && end_hit && (rcvd_d != n_pkt)) err_d = 1'b1;
        if ((state_q == S_WAIT) && MEMOP_SYNC_END && !end_hit)  err_d = 1'b1;
        if (LOAD_VALID && (state_q != S_LOAD)) err_d = 1'b1;
        if (STORE_CREDIT && !in_tx)            err_d = 1'b1;
        if (ISSUE_VALID && !push)              err_d = 1'b1;
        if (disp && !(|hit) && !push_hit)      err_d = 1'b1;
        if (pop) begin
            sent_d = '0;
            rcvd_d = '0;
            csum_d = '0;
        end
    end

    always_comb begin
        SYNC_START         = (state_q == S_SYNC);
        STORE_VALID        = store_valid;
        STORE_DATA         = store_valid ? {(MEMDATA_W/32){sent_q}} : '0;
        ISSUE_CREDIT       = pop;
        ERR                = err_q;
        COMPLETED_VALID    = 1'b0;
        COMPLETED_SBID     = '0;
        COMPLETED_DEST_REG = '0;
        if (state_q == S_COMP) begin
            COMPLETED_VALID = 1'b1;
            COMPLETED_SBID  = h_sbid;
            unique case (1'b1)
                is_load:  COMPLETED_DEST_REG = csum_q;
                is_store: COMPLETED_DEST_REG = {32'd0, sent_q};
                default:  COMPLETED_DEST_REG = '0;
            endcase
        end
    end
endmodule
